cr_huf_comp_sim_sa: RTL and testbench

- Size-acceptor that sits on the consumer side of the Huffman size-simulation interface.
- Tracks the per-frame LUT write stream (hw_lut_*) and waits for size-ready (st_sa_size_rdy).
- Latches the final simulated bit size, converts it to bytes and presents one result per frame to downstream header/mode-select logic with a valid/ready handshake.
- Pulses sa_st_read_done to release the simulator for the next frame.

---
 rtl/cr_huf_comp_sim_sa_pkg.sv | 38 +++
 rtl/cr_huf_comp_sim_sa_conv.sv | 22 ++
 rtl/cr_huf_comp_sim_sa.sv | 165 ++++++++++++++++
 tb/tb_cr_huf_comp_sim_sa.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_huf_comp_sim_sa_pkg.sv
// Shared types for the Huffman size-simulation acceptor: FSM states, frame EOB
// encoding and the latched per-frame result record.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 4
`endif

package cr_huf_compPKG;

  localparam int SA_DAT_WIDTH  = 10;
  localparam int SA_SIZE_WIDTH = 20;
  localparam int SA_SEQ_WIDTH  = `CREOLE_HC_SEQID_WIDTH;

  typedef enum logic [1:0] {
    MIDDLE      = 2'd0,
    LAST        = 2'd1,
    PASS_THRU   = 2'd2,
    MIDDLE_LAST = 2'd3
  } e_pipe_eob;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2,
    RELEASE = 2'd3
  } e_sa_state;

  // Field widths track the default DAT_WIDTH / SIZE_WIDTH of the acceptor.
  typedef struct packed {
    logic [SA_SIZE_WIDTH-1:0] bits;
    logic [SA_SIZE_WIDTH-4:0] bytes;
    logic                     over;
    logic [SA_DAT_WIDTH-1:0]  used;
    logic [SA_SEQ_WIDTH-1:0]  seq_id;
    e_pipe_eob                eob;
    logic                     err;
  } s_sa_size_result;

endpackage

// File: rtl/cr_huf_comp_sim_sa_conv.sv
// Bits-to-bytes ceiling with saturation into the byte field, plus the
// over-limit compare against the configured maximum.
module cr_huf_comp_sim_sa_conv #(
  parameter int SIZE_WIDTH = 20
) (
  input  logic [SIZE_WIDTH-1:0] bits_i,
  input  logic [SIZE_WIDTH-4:0] max_bytes_i,
  output logic [SIZE_WIDTH-4:0] bytes_o,
  output logic                  over_o
);

  logic [SIZE_WIDTH:0]   sum_s;
  logic [SIZE_WIDTH-3:0] full_s;

  assign sum_s  = {1'b0, bits_i} + {{(SIZE_WIDTH-2){1'b0}}, 3'd7};
  assign full_s = sum_s[SIZE_WIDTH:3];

  // Compare on the unsaturated value so a saturated result is always over.
  assign over_o  = (full_s > {1'b0, max_bytes_i});
  assign bytes_o = full_s[SIZE_WIDTH-3] ? {(SIZE_WIDTH-3){1'b1}} : full_s[SIZE_WIDTH-4:0];

endmodule

// File: rtl/cr_huf_comp_sim_sa.sv
// Size acceptor: follows the LUT write stream of a frame, latches the final
// simulated size once ready, presents it downstream and releases the simulator.
module cr_huf_comp_sim_sa
  import cr_huf_compPKG::*;
#(
  parameter int DAT_WIDTH  = 10,
  parameter int SIZE_WIDTH = 20
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              hw_lut_wr,
  input  logic [1:0]                        hw_lut_wr_val,
  input  logic [DAT_WIDTH-2:0]              hw_lut_wr_addr,
  input  logic                              hw_lut_wr_done,
  input  logic [`CREOLE_HC_SEQID_WIDTH-1:0] hw_lut_seq_id,
  input  logic [SIZE_WIDTH-1:0]             hw_lut_sim_size,
  input  logic                              st_sa_size_rdy,
  input  logic [`CREOLE_HC_SEQID_WIDTH-1:0] st_sa_size_seq_id,
  input  e_pipe_eob                         st_sa_eob,
  input  logic                              sa_out_rdy,
  input  logic [SIZE_WIDTH-4:0]             cfg_max_bytes,
  output logic                              sa_st_read_done,
  output logic                              sa_out_vld,
  output logic [SIZE_WIDTH-1:0]             sa_out_bits,
  output logic [SIZE_WIDTH-4:0]             sa_out_bytes,
  output logic                              sa_out_over,
  output logic [DAT_WIDTH-1:0]              sa_out_used,
  output logic [`CREOLE_HC_SEQID_WIDTH-1:0] sa_out_seq_id,
  output e_pipe_eob                         sa_out_eob,
  output logic                              sa_out_err,
  output logic                              sa_proto_err
);

  e_sa_state                         state_q;
  logic [`CREOLE_HC_SEQID_WIDTH-1:0] seq_q;
  logic [DAT_WIDTH-2:0]              prev_addr_q;
  logic [DAT_WIDTH-1:0]              used_q;
  logic                              done_seen_q;
  logic                              err_q;
  logic                              vld_q;
  logic                              read_done_q;
  logic                              proto_err_q;
  s_sa_size_result                   res_q;

  logic [DAT_WIDTH-1:0]  used_d;
  logic                  err_d;
  logic                  done_d;
  logic [DAT_WIDTH-2:0]  addr_exp_s;
  logic [SIZE_WIDTH-4:0] conv_bytes_s;
  logic                  conv_over_s;

  cr_huf_comp_sim_sa_conv #(
    .SIZE_WIDTH (SIZE_WIDTH)
  ) u_conv (
    .bits_i      (hw_lut_sim_size),
    .max_bytes_i (cfg_max_bytes),
    .bytes_o     (conv_bytes_s),
    .over_o      (conv_over_s)
  );

  assign addr_exp_s = prev_addr_q + {{(DAT_WIDTH-2){1'b0}}, 1'b1};
  assign done_d     = done_seen_q | hw_lut_wr_done;

  // COLLECT-phase update, so a write coinciding with size-ready is counted.
  always_comb begin
    used_d = used_q;
    err_d  = err_q;
    if (hw_lut_wr) begin
      if (hw_lut_wr_val != 2'd0) begin
        used_d = used_q + {{(DAT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        used_d = used_q;
      end
      err_d = err_q | (hw_lut_wr_addr != addr_exp_s);
    end else begin
      used_d = used_q;
      err_d  = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      seq_q       <= '0;
      prev_addr_q <= '0;
      used_q      <= '0;
      done_seen_q <= 1'b0;
      err_q       <= 1'b0;
      vld_q       <= 1'b0;
      read_done_q <= 1'b0;
      proto_err_q <= 1'b0;
      res_q       <= '{bits: '0, bytes: '0, over: 1'b0, used: '0,
                       seq_id: '0, eob: MIDDLE, err: 1'b0};
    end else begin
      read_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A lingering size-ready from the previous frame is deliberately ignored here.
          if (hw_lut_wr) begin
            state_q     <= COLLECT;
            seq_q       <= hw_lut_seq_id;
            prev_addr_q <= hw_lut_wr_addr;
            used_q      <= {{(DAT_WIDTH-1){1'b0}}, (hw_lut_wr_val != 2'd0)};
            done_seen_q <= hw_lut_wr_done;
            err_q       <= 1'b0;
          end
        end
        COLLECT: begin
          if (hw_lut_wr) begin
            prev_addr_q <= hw_lut_wr_addr;
          end
          used_q      <= used_d;
          err_q       <= err_d;
          done_seen_q <= done_d;
          if (st_sa_size_rdy && done_d) begin
            state_q      <= PRESENT;
            vld_q        <= 1'b1;
            res_q.bits   <= hw_lut_sim_size;
            res_q.bytes  <= conv_bytes_s;
            res_q.over   <= conv_over_s;
            res_q.used   <= used_d;
            res_q.seq_id <= st_sa_size_seq_id;
            res_q.eob    <= st_sa_eob;
            res_q.err    <= err_d | (st_sa_size_seq_id != seq_q);
          end
        end
        PRESENT: begin
          if (hw_lut_wr) begin
            proto_err_q <= 1'b1;
          end
          if (sa_out_rdy) begin
            state_q     <= RELEASE;
            vld_q       <= 1'b0;
            read_done_q <= 1'b1;
          end
        end
        RELEASE: begin
          if (hw_lut_wr) begin
            proto_err_q <= 1'b1;
          end
          state_q     <= IDLE;
          used_q      <= '0;
          prev_addr_q <= '0;
          done_seen_q <= 1'b0;
          err_q       <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sa_st_read_done = read_done_q;
  assign sa_out_vld      = vld_q;
  assign sa_out_bits     = res_q.bits;
  assign sa_out_bytes    = res_q.bytes;
  assign sa_out_over     = res_q.over;
  assign sa_out_used     = res_q.used;
  assign sa_out_seq_id   = res_q.seq_id;
  assign sa_out_eob      = res_q.eob;
  assign sa_out_err      = res_q.err;
  assign sa_proto_err    = proto_err_q;

endmodule

// File: tb/tb_cr_huf_comp_sim_sa.sv
// Directed bench for the size acceptor: a vector table of short frames for the
// byte conversion, plus hand-written sequences for the multi-cycle corners.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 4
`endif

module tb_cr_huf_comp_sim_sa;
  import cr_huf_compPKG::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        hw_lut_wr;
  logic [1:0]  hw_lut_wr_val;
  logic [8:0]  hw_lut_wr_addr;
  logic        hw_lut_wr_done;
  logic [3:0]  hw_lut_seq_id;
  logic [19:0] hw_lut_sim_size;
  logic        st_sa_size_rdy;
  logic [3:0]  st_sa_size_seq_id;
  e_pipe_eob   st_sa_eob;
  logic        sa_out_rdy;
  logic [16:0] cfg_max_bytes;
  logic        sa_st_read_done;
  logic        sa_out_vld;
  logic [19:0] sa_out_bits;
  logic [16:0] sa_out_bytes;
  logic        sa_out_over;
  logic [9:0]  sa_out_used;
  logic [3:0]  sa_out_seq_id;
  e_pipe_eob   sa_out_eob;
  logic        sa_out_err;
  logic        sa_proto_err;

  int checks = 0;
  int errors = 0;

  cr_huf_comp_sim_sa dut (
    .clk               (clk),
    .rst               (rst),
    .hw_lut_wr         (hw_lut_wr),
    .hw_lut_wr_val     (hw_lut_wr_val),
    .hw_lut_wr_addr    (hw_lut_wr_addr),
    .hw_lut_wr_done    (hw_lut_wr_done),
    .hw_lut_seq_id     (hw_lut_seq_id),
    .hw_lut_sim_size   (hw_lut_sim_size),
    .st_sa_size_rdy    (st_sa_size_rdy),
    .st_sa_size_seq_id (st_sa_size_seq_id),
    .st_sa_eob         (st_sa_eob),
    .sa_out_rdy        (sa_out_rdy),
    .cfg_max_bytes     (cfg_max_bytes),
    .sa_st_read_done   (sa_st_read_done),
    .sa_out_vld        (sa_out_vld),
    .sa_out_bits       (sa_out_bits),
    .sa_out_bytes      (sa_out_bytes),
    .sa_out_over       (sa_out_over),
    .sa_out_used       (sa_out_used),
    .sa_out_seq_id     (sa_out_seq_id),
    .sa_out_eob        (sa_out_eob),
    .sa_out_err        (sa_out_err),
    .sa_proto_err      (sa_proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [19:0] size;
    logic [16:0] cfg;
    e_pipe_eob   eob;
    logic [3:0]  seq;
    logic [16:0] exp_bytes;
    logic        exp_over;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n writes with val=3 from start (one address skipped from index gap_at);
  // the last write carries done and size-ready together.
  task automatic do_frame(input int n, input int start, input int gap_at,
                          input logic [3:0] wseq, input logic [3:0] sseq,
                          input logic [19:0] size, input e_pipe_eob eob,
                          input logic [16:0] cfg);
    for (int i = 0; i < n; i++) begin
      hw_lut_wr         = 1'b1;
      hw_lut_wr_val     = 2'd3;
      hw_lut_wr_addr    = 9'(start + i + ((i >= gap_at) ? 1 : 0));
      hw_lut_seq_id     = wseq;
      hw_lut_sim_size   = size;
      st_sa_size_seq_id = sseq;
      st_sa_eob         = eob;
      cfg_max_bytes     = cfg;
      hw_lut_wr_done    = (i == n - 1);
      st_sa_size_rdy    = (i == n - 1);
      tick();
      hw_lut_wr      = 1'b0;
      hw_lut_wr_done = 1'b0;
      st_sa_size_rdy = 1'b0;
    end
  endtask

  task automatic release_frame(input string name);
    sa_out_rdy = 1'b1;
    tick();
    chk({name, "_read_done"}, {31'd0, sa_st_read_done}, 32'd1);
    chk({name, "_vld_low"}, {31'd0, sa_out_vld}, 32'd0);
    sa_out_rdy = 1'b0;
    tick();
    chk({name, "_read_done_end"}, {31'd0, sa_st_read_done}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{size: 20'd0,       cfg: 17'd0,    eob: MIDDLE, seq: 4'd1, exp_bytes: 17'd0,       exp_over: 1'b0};
    vecs[1] = '{size: 20'hFFFFF,   cfg: 17'd1000, eob: LAST,   seq: 4'd2, exp_bytes: 17'h1FFFF,   exp_over: 1'b1};
    vecs[2] = '{size: 20'd1001,    cfg: 17'd126,  eob: LAST,   seq: 4'd7, exp_bytes: 17'd126,     exp_over: 1'b0};
    vecs[3] = '{size: 20'd1001,    cfg: 17'd125,  eob: MIDDLE, seq: 4'd8, exp_bytes: 17'd126,     exp_over: 1'b1};
    vecs[4] = '{size: 20'd8,       cfg: 17'd0,    eob: PASS_THRU, seq: 4'd9, exp_bytes: 17'd1,    exp_over: 1'b1};
    vecs[5] = '{size: 20'd9,       cfg: 17'd2,    eob: MIDDLE, seq: 4'd15, exp_bytes: 17'd2,      exp_over: 1'b0};

    rst = 1'b1;
    hw_lut_wr = 1'b0; hw_lut_wr_val = 2'd0; hw_lut_wr_addr = 9'd0; hw_lut_wr_done = 1'b0;
    hw_lut_seq_id = 4'd0; hw_lut_sim_size = 20'd0; st_sa_size_rdy = 1'b0;
    st_sa_size_seq_id = 4'd0; st_sa_eob = MIDDLE; sa_out_rdy = 1'b0; cfg_max_bytes = 17'd0;
    tick(); tick();
    chk("rst_vld", {31'd0, sa_out_vld}, 32'd0);
    chk("rst_read_done", {31'd0, sa_st_read_done}, 32'd0);
    chk("rst_bits", {12'd0, sa_out_bits}, 32'd0);
    chk("rst_used", {22'd0, sa_out_used}, 32'd0);
    chk("rst_eob", {30'd0, sa_out_eob}, {30'd0, MIDDLE});
    chk("rst_proto", {31'd0, sa_proto_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Nominal frame, ready already high before valid.
    sa_out_rdy = 1'b1;
    do_frame(511, 1, 1000, 4'd5, 4'd5, 20'd1001, LAST, 17'd1000);
    chk("nom_vld", {31'd0, sa_out_vld}, 32'd1);
    chk("nom_bits", {12'd0, sa_out_bits}, 32'd1001);
    chk("nom_bytes", {15'd0, sa_out_bytes}, 32'd126);
    chk("nom_over", {31'd0, sa_out_over}, 32'd0);
    chk("nom_used", {22'd0, sa_out_used}, 32'd511);
    chk("nom_seq", {28'd0, sa_out_seq_id}, 32'd5);
    chk("nom_eob", {30'd0, sa_out_eob}, {30'd0, LAST});
    chk("nom_err", {31'd0, sa_out_err}, 32'd0);
    release_frame("nom");

    // Conversion table.
    for (int v = 0; v < 6; v++) begin
      do_frame(2, 0, 1000, vecs[v].seq, vecs[v].seq, vecs[v].size, vecs[v].eob, vecs[v].cfg);
      chk($sformatf("vec%0d_vld", v), {31'd0, sa_out_vld}, 32'd1);
      chk($sformatf("vec%0d_bits", v), {12'd0, sa_out_bits}, {12'd0, vecs[v].size});
      chk($sformatf("vec%0d_bytes", v), {15'd0, sa_out_bytes}, {15'd0, vecs[v].exp_bytes});
      chk($sformatf("vec%0d_over", v), {31'd0, sa_out_over}, {31'd0, vecs[v].exp_over});
      chk($sformatf("vec%0d_used", v), {22'd0, sa_out_used}, 32'd2);
      chk($sformatf("vec%0d_eob", v), {30'd0, sa_out_eob}, {30'd0, vecs[v].eob});
      chk($sformatf("vec%0d_seq", v), {28'd0, sa_out_seq_id}, {28'd0, vecs[v].seq});
      chk($sformatf("vec%0d_err", v), {31'd0, sa_out_err}, 32'd0);
      release_frame($sformatf("vec%0d", v));
    end

    // Backpressure: hold ready low for 10 cycles.
    do_frame(3, 10, 1000, 4'd6, 4'd6, 20'd77, LAST, 17'd9);
    for (int c = 0; c < 10; c++) begin
      chk("bp_vld", {31'd0, sa_out_vld}, 32'd1);
      chk("bp_bits", {12'd0, sa_out_bits}, 32'd77);
      chk("bp_bytes", {15'd0, sa_out_bytes}, 32'd10);
      chk("bp_over", {31'd0, sa_out_over}, 32'd1);
      chk("bp_no_read_done", {31'd0, sa_st_read_done}, 32'd0);
      tick();
    end
    release_frame("bp");

    // Address gap 1,2,4.
    do_frame(3, 1, 2, 4'd2, 4'd2, 20'd16, LAST, 17'd9);
    chk("gap_err", {31'd0, sa_out_err}, 32'd1);
    chk("gap_used", {22'd0, sa_out_used}, 32'd3);
    release_frame("gap");

    // Seq mismatch.
    do_frame(3, 1, 1000, 4'd3, 4'd4, 20'd16, LAST, 17'd9);
    chk("seq_err", {31'd0, sa_out_err}, 32'd1);
    chk("seq_out", {28'd0, sa_out_seq_id}, 32'd4);

    // Stale size-ready through RELEASE into IDLE.
    sa_out_rdy = 1'b1;
    tick();
    chk("stale_read_done", {31'd0, sa_st_read_done}, 32'd1);
    sa_out_rdy = 1'b0;
    st_sa_size_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stale_no_vld", {31'd0, sa_out_vld}, 32'd0);
      chk("stale_no_read_done", {31'd0, sa_st_read_done}, 32'd0);
    end
    st_sa_size_rdy = 1'b0;
    do_frame(2, 5, 1000, 4'd1, 4'd1, 20'd24, MIDDLE, 17'd3);
    chk("after_stale_vld", {31'd0, sa_out_vld}, 32'd1);
    chk("after_stale_err", {31'd0, sa_out_err}, 32'd0);
    chk("after_stale_bytes", {15'd0, sa_out_bytes}, 32'd3);
    release_frame("after_stale");

    // Reset mid-COLLECT after 100 writes; done never arrives.
    for (int i = 0; i < 100; i++) begin
      hw_lut_wr = 1'b1; hw_lut_wr_val = 2'd1; hw_lut_wr_addr = 9'(i); hw_lut_seq_id = 4'd9;
      tick();
    end
    hw_lut_wr = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_rst_vld", {31'd0, sa_out_vld}, 32'd0);
    chk("abort_rst_used", {22'd0, sa_out_used}, 32'd0);
    tick();
    rst = 1'b0;
    st_sa_size_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort_no_read_done", {31'd0, sa_st_read_done}, 32'd0);
      chk("abort_no_vld", {31'd0, sa_out_vld}, 32'd0);
    end
    st_sa_size_rdy = 1'b0;
    do_frame(4, 0, 1000, 4'd2, 4'd2, 20'd40, LAST, 17'd5);
    chk("new_used", {22'd0, sa_out_used}, 32'd4);
    chk("new_err", {31'd0, sa_out_err}, 32'd0);
    chk("new_over", {31'd0, sa_out_over}, 32'd0);
    chk("proto_before", {31'd0, sa_proto_err}, 32'd0);

    // Write while PRESENT.
    hw_lut_wr = 1'b1; hw_lut_wr_val = 2'd3; hw_lut_wr_addr = 9'd4;
    tick();
    hw_lut_wr = 1'b0;
    chk("proto_set", {31'd0, sa_proto_err}, 32'd1);
    chk("proto_used_held", {22'd0, sa_out_used}, 32'd4);
    chk("proto_vld_held", {31'd0, sa_out_vld}, 32'd1);
    release_frame("proto");
    chk("proto_sticky", {31'd0, sa_proto_err}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
